// File: rtl/ram_rr_arbiter.sv
// Round-robin arbiter and access sequencer for a single-port synchronous RAM.
// Two requesters are serialised into one-cycle RAM strobes; read data returns with a valid pulse.
module ram_rr_arbiter #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 4,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_i,
  input  logic              we0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [DATA_W-1:0] wdata0_i,
  output logic              gnt0_o,
  output logic              rvalid0_o,
  input  logic              req1_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              gnt1_o,
  output logic              rvalid1_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              busy_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_rden_o,
  output logic              ram_wren_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  localparam int unsigned     CntW    = $clog2(RD_LAT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(RD_LAT - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StWaitRd} state_e;

  state_e            r_state, w_state_nxt;
  logic              r_owner, w_owner_nxt;
  logic              r_we, w_we_nxt;
  logic              r_last, w_last_nxt;
  logic [CntW-1:0]   r_cnt, w_cnt_nxt;
  logic              r_gnt0, w_gnt0_nxt;
  logic              r_gnt1, w_gnt1_nxt;
  logic              r_rvalid0, w_rvalid0_nxt;
  logic              r_rvalid1, w_rvalid1_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_rden, w_rden_nxt;
  logic              r_wren, w_wren_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
  logic [DATA_W-1:0] r_rdata, w_rdata_nxt;
  logic              w_sel;

  // On a tie the requester not granted last wins; otherwise whichever is asking.
  assign w_sel = (req0_i && req1_i) ? ~r_last : req1_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= StIdle;
      r_owner   <= 1'b0;
      r_we      <= 1'b0;
      r_last    <= 1'b1;
      r_cnt     <= '0;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_busy    <= 1'b0;
      r_rden    <= 1'b0;
      r_wren    <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_owner   <= w_owner_nxt;
      r_we      <= w_we_nxt;
      r_last    <= w_last_nxt;
      r_cnt     <= w_cnt_nxt;
      r_gnt0    <= w_gnt0_nxt;
      r_gnt1    <= w_gnt1_nxt;
      r_rvalid0 <= w_rvalid0_nxt;
      r_rvalid1 <= w_rvalid1_nxt;
      r_busy    <= w_busy_nxt;
      r_rden    <= w_rden_nxt;
      r_wren    <= w_wren_nxt;
      r_addr    <= w_addr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_rdata   <= w_rdata_nxt;
    end
  end

  // Outputs are registered, so the strobes and grant seen during ACCESS are
  // computed on the IDLE -> ACCESS transition.
  always_comb begin
    w_state_nxt   = r_state;
    w_owner_nxt   = r_owner;
    w_we_nxt      = r_we;
    w_last_nxt    = r_last;
    w_cnt_nxt     = r_cnt;
    w_addr_nxt    = r_addr;
    w_wdata_nxt   = r_wdata;
    w_rdata_nxt   = r_rdata;
    w_gnt0_nxt    = 1'b0;
    w_gnt1_nxt    = 1'b0;
    w_rvalid0_nxt = 1'b0;
    w_rvalid1_nxt = 1'b0;
    w_rden_nxt    = 1'b0;
    w_wren_nxt    = 1'b0;

    case (r_state)
      StIdle: begin
        if (req0_i || req1_i) begin
          w_owner_nxt = w_sel;
          w_we_nxt    = w_sel ? we1_i : we0_i;
          w_addr_nxt  = w_sel ? addr1_i : addr0_i;
          w_wdata_nxt = w_sel ? wdata1_i : wdata0_i;
          w_gnt0_nxt  = ~w_sel;
          w_gnt1_nxt  = w_sel;
          w_wren_nxt  = w_we_nxt;
          w_rden_nxt  = ~w_we_nxt;
          w_state_nxt = StAccess;
        end
      end
      StAccess: begin
        w_last_nxt  = r_owner;
        w_cnt_nxt   = '0;
        w_state_nxt = r_we ? StIdle : StWaitRd;
      end
      StWaitRd: begin
        if (r_cnt == CntLast) begin
          w_rdata_nxt   = ram_rdata_i;
          w_rvalid0_nxt = ~r_owner;
          w_rvalid1_nxt = r_owner;
          w_state_nxt   = StIdle;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase

    w_busy_nxt = (w_state_nxt != StIdle);
  end

  assign gnt0_o      = r_gnt0;
  assign gnt1_o      = r_gnt1;
  assign rvalid0_o   = r_rvalid0;
  assign rvalid1_o   = r_rvalid1;
  assign rdata_o     = r_rdata;
  assign busy_o      = r_busy;
  assign ram_addr_o  = r_addr;
  assign ram_rden_o  = r_rden;
  assign ram_wren_o  = r_wren;
  assign ram_wdata_o = r_wdata;

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Bench for ram_rr_arbiter: two instances (RD_LAT 1 and 3) each with a behavioural RAM.
// Directed scenarios plus a randomized run checked cycle by cycle against a timing/order model.
module tb_ram_rr_arbiter;

  localparam int LAT1 = 1;
  localparam int LAT3 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance with RD_LAT = 1
  logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [3:0] addr0 = 4'h0, wdata0 = 4'h0, addr1 = 4'h0, wdata1 = 4'h0;
  logic       gnt0, gnt1, rv0, rv1, busy, rden, wren;
  logic [3:0] rdata, raddr, rwdata, ram_rdata;

  // Instance with RD_LAT = 3 (requester 1 unused)
  logic       t_req0 = 1'b0, t_we0 = 1'b0, t_req1 = 1'b0, t_we1 = 1'b0;
  logic [3:0] t_addr0 = 4'h0, t_wdata0 = 4'h0, t_addr1 = 4'h0, t_wdata1 = 4'h0;
  logic       t_gnt0, t_gnt1, t_rv0, t_rv1, t_busy, t_rden, t_wren;
  logic [3:0] t_rdata, t_raddr, t_rwdata, t_ram_rdata;

  ram_rr_arbiter #(.ADDR_W(4), .DATA_W(4), .RD_LAT(LAT1)) u_dut1 (
    .clk_i(clk), .rst_i(rst),
    .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wdata0),
    .gnt0_o(gnt0), .rvalid0_o(rv0),
    .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1),
    .gnt1_o(gnt1), .rvalid1_o(rv1),
    .rdata_o(rdata), .busy_o(busy),
    .ram_addr_o(raddr), .ram_rden_o(rden), .ram_wren_o(wren), .ram_wdata_o(rwdata),
    .ram_rdata_i(ram_rdata)
  );

  ram_rr_arbiter #(.ADDR_W(4), .DATA_W(4), .RD_LAT(LAT3)) u_dut3 (
    .clk_i(clk), .rst_i(rst),
    .req0_i(t_req0), .we0_i(t_we0), .addr0_i(t_addr0), .wdata0_i(t_wdata0),
    .gnt0_o(t_gnt0), .rvalid0_o(t_rv0),
    .req1_i(t_req1), .we1_i(t_we1), .addr1_i(t_addr1), .wdata1_i(t_wdata1),
    .gnt1_o(t_gnt1), .rvalid1_o(t_rv1),
    .rdata_o(t_rdata), .busy_o(t_busy),
    .ram_addr_o(t_raddr), .ram_rden_o(t_rden), .ram_wren_o(t_wren), .ram_wdata_o(t_rwdata),
    .ram_rdata_i(t_ram_rdata)
  );

  // RAMs drive garbage except in the cycle(s) the read data is valid
  logic [3:0] mem1 [16];
  logic [3:0] mem3 [16];
  logic [3:0] p0, p1, p2;
  assign t_ram_rdata = p2;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem1[i] <= 4'h0;
      ram_rdata <= 4'h0;
    end else begin
      if (wren) mem1[raddr] <= rwdata;
      ram_rdata <= rden ? mem1[raddr] : 4'($urandom);
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem3[i] <= 4'h0;
      p0 <= 4'h0;
      p1 <= 4'h0;
      p2 <= 4'h0;
    end else begin
      if (t_wren) mem3[t_raddr] <= t_rwdata;
      p0 <= t_rden ? mem3[t_raddr] : 4'($urandom);
      p1 <= p0;
      p2 <= p1;
    end
  end

  // Reference model state for the RD_LAT=1 instance
  logic [3:0] mm [16];
  logic       m_last;
  logic [3:0] m_addr, m_wdata, m_rdata;

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) mm[i] = 4'h0;
    m_last = 1'b1;
    m_addr = 4'h0;
    m_wdata = 4'h0;
    m_rdata = 4'h0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    n_total++;
    if ({gnt0, gnt1, rv0, rv1, busy, rden, wren, rdata, raddr, rwdata} !== 19'h0)
      $display("FAIL reset_dut1: got %h want 0",
               {gnt0, gnt1, rv0, rv1, busy, rden, wren, rdata, raddr, rwdata});
    else n_pass++;
    n_total++;
    if ({t_gnt0, t_gnt1, t_rv0, t_rv1, t_busy, t_rden, t_wren, t_rdata, t_raddr, t_rwdata} !== 19'h0)
      $display("FAIL reset_dut3: got %h want 0",
               {t_gnt0, t_gnt1, t_rv0, t_rv1, t_busy, t_rden, t_wren, t_rdata, t_raddr, t_rwdata});
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if ({gnt0, gnt1, busy, rden, wren} !== 5'b0)
      $display("FAIL reset_release_idle: got %b want 00000", {gnt0, gnt1, busy, rden, wren});
    else n_pass++;
    for (int i = 0; i < 16; i++) mm[i] = 4'h0;
    m_last = 1'b1;
    m_addr = 4'h0;
    m_wdata = 4'h0;
    m_rdata = 4'h0;
  endtask

  task automatic test_write();
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'h3; wdata0 = 4'hA;
    @(negedge clk);
    n_total++;
    if ({gnt0, gnt1, wren, rden, busy, raddr, rwdata} !== {5'b10101, 4'h3, 4'hA})
      $display("FAIL write_access: got %h want %h",
               {gnt0, gnt1, wren, rden, busy, raddr, rwdata}, {5'b10101, 4'h3, 4'hA});
    else n_pass++;
    req0 = 1'b0;
    @(negedge clk);
    n_total++;
    if ({gnt0, gnt1, wren, rden, busy, raddr, rwdata} !== {5'b00000, 4'h3, 4'hA})
      $display("FAIL write_after: got %h want %h",
               {gnt0, gnt1, wren, rden, busy, raddr, rwdata}, {5'b00000, 4'h3, 4'hA});
    else n_pass++;
    mm[3] = 4'hA;
    m_last = 1'b0;
  endtask

  task automatic test_readback();
    req1 = 1'b1; we1 = 1'b0; addr1 = 4'h3; wdata1 = 4'($urandom);
    @(negedge clk);
    n_total++;
    if ({gnt0, gnt1, rden, wren, rv0, rv1, busy, raddr} !== {7'b0110001, 4'h3})
      $display("FAIL read_gnt: got %h want %h",
               {gnt0, gnt1, rden, wren, rv0, rv1, busy, raddr}, {7'b0110001, 4'h3});
    else n_pass++;
    req1 = 1'b0;
    @(negedge clk);
    n_total++;
    if ({gnt1, rden, rv0, rv1, busy} !== 5'b00001)
      $display("FAIL read_wait: got %b want 00001", {gnt1, rden, rv0, rv1, busy});
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({rv0, rv1, busy, rdata} !== {3'b010, 4'hA})
      $display("FAIL read_rvalid: got %h want %h", {rv0, rv1, busy, rdata}, {3'b010, 4'hA});
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({rv0, rv1, rdata} !== {2'b00, 4'hA})
      $display("FAIL read_hold: got %h want %h", {rv0, rv1, rdata}, {2'b00, 4'hA});
    else n_pass++;
    m_last = 1'b1;
    m_rdata = 4'hA;
  endtask

  task automatic test_tie();
    int n_g0 = 0, n_g1 = 0, k_g0 = 0, k_g1 = 0, n_wr = 0, n_rd = 0, n_both = 0;
    logic [3:0] d0, d1, a_g0, a_g1, w_g0, w_g1;
    apply_reset();
    d0 = 4'($urandom);
    d1 = 4'($urandom);
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'h1; wdata0 = d0;
    req1 = 1'b1; we1 = 1'b1; addr1 = 4'h2; wdata1 = d1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (wren) n_wr++;
      if (rden) n_rd++;
      if (wren && rden) n_both++;
      if (gnt0) begin n_g0++; k_g0 = k; a_g0 = raddr; w_g0 = rwdata; req0 = 1'b0; end
      if (gnt1) begin n_g1++; k_g1 = k; a_g1 = raddr; w_g1 = rwdata; req1 = 1'b0; end
    end
    n_total++;
    if ({n_g0, n_g1} !== {32'd1, 32'd1})
      $display("FAIL tie_counts: got %0d/%0d want 1/1", n_g0, n_g1);
    else n_pass++;
    n_total++;
    if ({k_g0, k_g1} !== {32'd1, 32'd3})
      $display("FAIL tie_order: got gnt0@%0d gnt1@%0d want 1,3", k_g0, k_g1);
    else n_pass++;
    n_total++;
    if ({a_g0, w_g0, a_g1, w_g1} !== {4'h1, d0, 4'h2, d1})
      $display("FAIL tie_cmd: got %h want %h", {a_g0, w_g0, a_g1, w_g1}, {4'h1, d0, 4'h2, d1});
    else n_pass++;
    n_total++;
    if ({n_wr, n_rd, n_both} !== {32'd2, 32'd0, 32'd0})
      $display("FAIL tie_strobes: got wr=%0d rd=%0d both=%0d want 2,0,0", n_wr, n_rd, n_both);
    else n_pass++;
    mm[1] = d0;
    mm[2] = d1;
    m_last = 1'b1;
  endtask

  task automatic test_fairness();
    int ng = 0, nbad = 0, neven = 0;
    logic first;
    logic [1:0] exp_oh;
    first = ~m_last;
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'($urandom); wdata0 = 4'($urandom);
    req1 = 1'b1; we1 = 1'b1; addr1 = 4'($urandom); wdata1 = 4'($urandom);
    for (int k = 1; k <= 29; k++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        exp_oh = (first ^ ng[0]) ? 2'b01 : 2'b10;
        if ({gnt0, gnt1} !== exp_oh) nbad++;
        if (k % 2 == 0) neven++;
        ng++;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    n_total++;
    if (ng !== 15) $display("FAIL fair_count: got %0d grants want 15", ng);
    else n_pass++;
    n_total++;
    if ({nbad, neven} !== 64'd0)
      $display("FAIL fair_alternate: got %0d out-of-turn, %0d mistimed want 0,0", nbad, neven);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    n_total++;
    if ({gnt0, gnt1, busy} !== 3'b000)
      $display("FAIL fair_stop: got %b want 000", {gnt0, gnt1, busy});
    else n_pass++;
    mm[addr0] = wdata0;
    mm[addr1] = wdata1;
    m_last = first;
  endtask

  task automatic test_reset_midread();
    int nq = 0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 4'h1;
    @(negedge clk);
    n_total++;
    if ({gnt0, rden} !== 2'b11) $display("FAIL midread_gnt: got %b want 11", {gnt0, rden});
    else n_pass++;
    req0 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_total++;
    if ({gnt0, gnt1, rv0, rv1, busy, rden, wren, rdata, raddr, rwdata} !== 19'h0)
      $display("FAIL midread_async_clear: got %h want 0",
               {gnt0, gnt1, rv0, rv1, busy, rden, wren, rdata, raddr, rwdata});
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (rv0 || rv1 || busy || gnt0 || gnt1) nq++;
    end
    n_total++;
    if (nq !== 0) $display("FAIL midread_no_rvalid: got %0d active cycles want 0", nq);
    else n_pass++;
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'h4; wdata0 = 4'($urandom);
    req1 = 1'b1; we1 = 1'b1; addr1 = 4'h5; wdata1 = 4'($urandom);
    @(negedge clk);
    n_total++;
    if ({gnt0, gnt1} !== 2'b10) $display("FAIL midread_tie: got %b want 10", {gnt0, gnt1});
    else n_pass++;
    req0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_rdlat3();
    int gk = 0, vk = 0, bcnt = 0;
    logic [3:0] vd = 4'h0;
    logic [6:0] bmask = 7'h0;
    t_req0 = 1'b1; t_we0 = 1'b1; t_addr0 = 4'h7; t_wdata0 = 4'h5;
    @(negedge clk);
    n_total++;
    if ({t_gnt0, t_wren, t_rden, t_raddr, t_rwdata} !== {3'b110, 4'h7, 4'h5})
      $display("FAIL lat3_write: got %h want %h",
               {t_gnt0, t_wren, t_rden, t_raddr, t_rwdata}, {3'b110, 4'h7, 4'h5});
    else n_pass++;
    t_req0 = 1'b0;
    @(negedge clk);
    t_req0 = 1'b1; t_we0 = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (t_busy) begin bcnt++; bmask[k-1] = 1'b1; end
      if (t_gnt0) begin gk = k; t_req0 = 1'b0; end
      if (t_rv0) begin vk = k; vd = t_rdata; end
    end
    t_req0 = 1'b0;
    n_total++;
    if (gk !== 1) $display("FAIL lat3_gnt: got +%0d want +1", gk);
    else n_pass++;
    n_total++;
    if ({vk, vd} !== {32'd5, 4'h5}) $display("FAIL lat3_rvalid: got +%0d data %h want +5 data 5", vk, vd);
    else n_pass++;
    n_total++;
    if (bmask !== 7'b0001111) $display("FAIL lat3_busy: got %b (%0d cycles) want 0001111", bmask, bcnt);
    else n_pass++;
  endtask

  task automatic test_random();
    apply_reset();
    for (int s = 0; s < 60; s++) begin
      bit both, a, w1, w2, rd1, rd2;
      int d, c, g1, g2, v1, v2, free, s2, last_k;
      logic [3:0] x1, x2;
      logic       cwe [2];
      logic [3:0] cad [2];
      logic [3:0] cdt [2];
      both = 1'($urandom_range(0, 1));
      a = 1'($urandom_range(0, 1));
      d = both ? int'($urandom_range(0, 3)) : 0;
      for (int r = 0; r < 2; r++) begin
        cwe[r] = 1'($urandom_range(0, 1));
        cad[r] = 4'($urandom_range(0, 3));
        cdt[r] = 4'($urandom);
      end
      we0 = cwe[0]; addr0 = cad[0]; wdata0 = cdt[0];
      we1 = cwe[1]; addr1 = cad[1]; wdata1 = cdt[1];
      x1 = 4'h0; x2 = 4'h0; g2 = 0; v2 = 0; w2 = 1'b0; rd2 = 1'b0;
      c = cyc;
      // Command order, grant cycles and read results follow from the arbitration rules
      w1 = (both && d == 0) ? ~m_last : a;
      g1 = c + 1;
      rd1 = ~cwe[w1];
      if (rd1) x1 = mm[cad[w1]];
      else mm[cad[w1]] = cdt[w1];
      v1 = g1 + 1 + LAT1;
      free = rd1 ? v1 : g1 + 1;
      m_last = w1;
      last_k = free;
      if (both) begin
        w2 = ~w1;
        s2 = (c + d > free) ? c + d : free;
        g2 = s2 + 1;
        rd2 = ~cwe[w2];
        if (rd2) x2 = mm[cad[w2]];
        else mm[cad[w2]] = cdt[w2];
        v2 = g2 + 1 + LAT1;
        m_last = w2;
        last_k = rd2 ? v2 : g2 + 1;
      end
      if (a) req1 = 1'b1;
      else req0 = 1'b1;
      if (both && d == 0) begin
        if (a) req0 = 1'b1;
        else req1 = 1'b1;
      end
      for (int k = c; k <= last_k; k++) begin
        logic eg0, eg1, ev0, ev1, ewr, erd, eby;
        if (k != c) @(negedge clk);
        if (k == g1) begin m_addr = cad[w1]; m_wdata = cdt[w1]; end
        if (both && k == g2) begin m_addr = cad[w2]; m_wdata = cdt[w2]; end
        if (rd1 && k == v1) m_rdata = x1;
        if (both && rd2 && k == v2) m_rdata = x2;
        eg0 = (k == g1 && !w1) || (both && k == g2 && !w2);
        eg1 = (k == g1 && w1) || (both && k == g2 && w2);
        ev0 = (rd1 && k == v1 && !w1) || (both && rd2 && k == v2 && !w2);
        ev1 = (rd1 && k == v1 && w1) || (both && rd2 && k == v2 && w2);
        ewr = (k == g1 && !rd1) || (both && k == g2 && !rd2);
        erd = (k == g1 && rd1) || (both && k == g2 && rd2);
        eby = (k >= g1 && k <= g1 + (rd1 ? LAT1 : 0)) ||
              (both && k >= g2 && k <= g2 + (rd2 ? LAT1 : 0));
        n_total++;
        if ({gnt0, gnt1, rv0, rv1, wren, rden, busy, raddr, rwdata, rdata} !==
            {eg0, eg1, ev0, ev1, ewr, erd, eby, m_addr, m_wdata, m_rdata})
          $display("FAIL random step %0d cycle +%0d: got %h want %h", s, k - c,
                   {gnt0, gnt1, rv0, rv1, wren, rden, busy, raddr, rwdata, rdata},
                   {eg0, eg1, ev0, ev1, ewr, erd, eby, m_addr, m_wdata, m_rdata});
        else n_pass++;
        if (gnt0) req0 = 1'b0;
        if (gnt1) req1 = 1'b0;
        if (both && d > 0 && k == c + d) begin
          if (a) req0 = 1'b1;
          else req1 = 1'b1;
        end
      end
      req0 = 1'b0;
      req1 = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_readback();
    test_tie();
    test_fairness();
    test_reset_midread();
    test_rdlat3();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
